// File: rtl/sap_microseq_if.sv
// Handshake bundle between the SAP control block and the datapath it sequences.
// The master drives step/opcode/flags; the slave (sequencer) returns control and status.
interface sap_microseq_if #(
    parameter int unsigned OPCODE_W = 4,
    parameter int unsigned TW       = 3
);
    logic                step_en;
    logic [OPCODE_W-1:0] opcode;
    logic                flag_z;
    logic                flag_c;
    logic [14:0]         ctrl;
    logic [TW-1:0]       tstate;
    logic                instr_done;
    logic                halted;

    modport master (
        output step_en, opcode, flag_z, flag_c,
        input  ctrl, tstate, instr_done, halted
    );

    modport slave (
        input  step_en, opcode, flag_z, flag_c,
        output ctrl, tstate, instr_done, halted
    );
endinterface

// File: rtl/sap_microseq.sv
// Microcoded SAP sequencer: fetch T0..T2, opcode-dependent execute T3..T5 with early
// termination, conditional jumps, sticky halt and single-step freeze.
module sap_microseq #(
    parameter int unsigned OPCODE_W      = 4,
    parameter int unsigned T_MAX         = 6,
    parameter logic [14:0] CTRL_IDLE     = 15'h0FE3,
    parameter bit          HALT_ON_UNDEF = 1'b0
) (
    input logic           clk,
    input logic           rst,
    sap_microseq_if.slave bus
);
    localparam int unsigned TW = $clog2(T_MAX + 1);

    // Masks of the control bits this sequencer ever drives to their active level.
    localparam logic [14:0] M_PC_INC    = 15'h4000;
    localparam logic [14:0] M_PC_EN     = 15'h2000;
    localparam logic [14:0] M_PC_LOAD   = 15'h1000;
    localparam logic [14:0] M_MAR_ADDR  = 15'h0800;
    localparam logic [14:0] M_RAM_EN    = 15'h0200;
    localparam logic [14:0] M_RAM_LOAD  = 15'h0100;
    localparam logic [14:0] M_IR_LOAD   = 15'h0080;
    localparam logic [14:0] M_IR_EN     = 15'h0040;
    localparam logic [14:0] M_REGA_LOAD = 15'h0020;
    localparam logic [14:0] M_REGA_EN   = 15'h0010;
    localparam logic [14:0] M_ADDER_SUB = 15'h0008;
    localparam logic [14:0] M_REGB_EN   = 15'h0004;
    localparam logic [14:0] M_REGB_LOAD = 15'h0002;
    localparam logic [14:0] M_OUT_LOAD  = 15'h0001;

    localparam logic [3:0] K_HLT = 4'd0;
    localparam logic [3:0] K_NOP = 4'd1;
    localparam logic [3:0] K_ADD = 4'd2;
    localparam logic [3:0] K_SUB = 4'd3;
    localparam logic [3:0] K_LDA = 4'd4;
    localparam logic [3:0] K_OUT = 4'd5;
    localparam logic [3:0] K_STA = 4'd6;
    localparam logic [3:0] K_JMP = 4'd7;
    localparam logic [3:0] K_JZ  = 4'd8;
    localparam logic [3:0] K_JC  = 4'd9;

    typedef enum logic [TW-1:0] {
        T0   = TW'(0),
        T1   = TW'(1),
        T2   = TW'(2),
        T3   = TW'(3),
        T4   = TW'(4),
        T5   = TW'(5),
        IDLE = TW'(T_MAX)
    } state_t;

    state_t              r_state;
    logic [14:0]         r_ctrl;
    logic                r_done;
    logic                r_halted;
    logic [OPCODE_W-1:0] r_op_q;
    logic                r_fz;
    logic                r_fc;

    logic [3:0]  w_kind_in;
    logic [3:0]  w_kind_q;
    state_t      w_next;
    logic [14:0] w_word_t3;
    logic [14:0] w_word_next;

    // Map a raw opcode to the instruction it executes; undefined ones become HLT or NOP.
    function automatic logic [3:0] f_kind(input logic [OPCODE_W-1:0] op);
        if (((op >> 4) == '0) && (op[3:0] <= 4'd9))
            return op[3:0];
        return HALT_ON_UNDEF ? K_HLT : K_NOP;
    endfunction

    function automatic logic [14:0] f_exec_word(input logic [3:0] k, input state_t s,
                                                 input logic fz, input logic fc);
        logic [14:0] m;
        m = '0;
        case (k)
            K_ADD, K_SUB: begin
                if (s == T3) m = M_IR_EN | M_MAR_ADDR;
                if (s == T4) m = M_RAM_EN | M_REGB_LOAD;
                if (s == T5) m = M_REGB_EN | M_REGA_LOAD | ((k == K_SUB) ? M_ADDER_SUB : 15'h0000);
            end
            K_LDA: begin
                if (s == T3) m = M_IR_EN | M_MAR_ADDR;
                if (s == T4) m = M_RAM_EN | M_REGA_LOAD;
            end
            K_OUT: if (s == T3) m = M_REGA_EN | M_OUT_LOAD;
            K_STA: begin
                if (s == T3) m = M_IR_EN | M_MAR_ADDR;
                if (s == T4) m = M_REGA_EN | M_RAM_LOAD;
            end
            K_JMP: if (s == T3) m = M_IR_EN | M_PC_LOAD;
            K_JZ:  if ((s == T3) && fz) m = M_IR_EN | M_PC_LOAD;
            K_JC:  if ((s == T3) && fc) m = M_IR_EN | M_PC_LOAD;
            default: m = '0;
        endcase
        return CTRL_IDLE ^ m;
    endfunction

    // Final T-state of each instruction; reaching it raises instr_done.
    function automatic state_t f_last(input logic [3:0] k);
        case (k)
            K_ADD, K_SUB: return T5;
            K_LDA, K_STA: return T4;
            default:      return T3;
        endcase
    endfunction

    assign w_kind_in   = f_kind(bus.opcode);
    assign w_kind_q    = f_kind(r_op_q);
    assign w_next      = state_t'(r_state + TW'(1));
    assign w_word_t3   = f_exec_word(w_kind_in, T3, bus.flag_z, bus.flag_c);
    assign w_word_next = f_exec_word(w_kind_q, w_next, r_fz, r_fc);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_ctrl   <= CTRL_IDLE;
            r_done   <= 1'b0;
            r_halted <= 1'b0;
            r_op_q   <= '0;
            r_fz     <= 1'b0;
            r_fc     <= 1'b0;
        end else if (bus.step_en && !r_halted) begin
            case (r_state)
                IDLE: begin
                    r_state <= T0;
                    r_ctrl  <= CTRL_IDLE ^ (M_PC_EN | M_MAR_ADDR);
                    r_done  <= 1'b0;
                end
                T0: begin
                    r_state <= T1;
                    r_ctrl  <= CTRL_IDLE ^ (M_RAM_EN | M_IR_LOAD);
                    r_done  <= 1'b0;
                end
                T1: begin
                    r_state <= T2;
                    r_ctrl  <= CTRL_IDLE ^ M_PC_INC;
                    r_done  <= 1'b0;
                end
                T2: begin
                    r_state  <= T3;
                    r_op_q   <= bus.opcode;
                    r_fz     <= bus.flag_z;
                    r_fc     <= bus.flag_c;
                    r_ctrl   <= w_word_t3;
                    r_done   <= (f_last(w_kind_in) == T3);
                    r_halted <= (w_kind_in == K_HLT);
                end
                T3, T4: begin
                    if (r_done) begin
                        r_state <= T0;
                        r_ctrl  <= CTRL_IDLE ^ (M_PC_EN | M_MAR_ADDR);
                        r_done  <= 1'b0;
                    end else begin
                        r_state <= w_next;
                        r_ctrl  <= w_word_next;
                        r_done  <= (f_last(w_kind_q) == w_next);
                    end
                end
                T5: begin
                    r_state <= T0;
                    r_ctrl  <= CTRL_IDLE ^ (M_PC_EN | M_MAR_ADDR);
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_ctrl  <= CTRL_IDLE;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ctrl       = r_ctrl;
    assign bus.tstate     = r_state;
    assign bus.instr_done = r_done;
    assign bus.halted     = r_halted;
endmodule

// File: tb/tb_sap_microseq.sv
// Bench for sap_microseq: directed scenarios plus random opcode/flag/step traffic,
// checked every cycle against an instruction-level reference model.
module tb_sap_microseq;
    localparam int unsigned TW     = 3;
    localparam logic [14:0] IDLE_W = 15'h0FE3;
    localparam int          T_IDLE = 6;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    sap_microseq_if #(.OPCODE_W(4), .TW(TW)) bus ();
    sap_microseq_if #(.OPCODE_W(4), .TW(TW)) bus_h ();

    sap_microseq #(.HALT_ON_UNDEF(1'b0)) u_dut (.clk(clk), .rst(rst), .bus(bus));
    sap_microseq #(.HALT_ON_UNDEF(1'b1)) u_dut_h (.clk(clk), .rst(rst), .bus(bus_h));

    // Reference model: the microcode of the current instruction as a list of words.
    bit          m_idle;
    bit          m_halt;
    int          m_pos;
    logic [14:0] m_words[$];

    // Drive control bit b to its active level (low for the _N signals).
    function automatic logic [14:0] act(input logic [14:0] w, input int b);
        logic [14:0] r;
        r    = w;
        r[b] = (b inside {0, 1, [5:11]}) ? 1'b0 : 1'b1;
        return r;
    endfunction

    function automatic logic [14:0] act2(input int a, input int b);
        return act(act(IDLE_W, a), b);
    endfunction

    task automatic model_reset();
        m_idle = 1'b1;
        m_halt = 1'b0;
        m_pos  = 0;
        m_words.delete();
    endtask

    task automatic model_fetch();
        m_words.delete();
        m_words.push_back(act2(13, 11));
        m_words.push_back(act2(9, 7));
        m_words.push_back(act(IDLE_W, 14));
        m_pos = 0;
    endtask

    task automatic model_exec(input logic [3:0] op, input bit fz, input bit fc);
        case (op)
            4'd0: begin m_words.push_back(IDLE_W); m_halt = 1'b1; end
            4'd2, 4'd3: begin
                m_words.push_back(act2(6, 11));
                m_words.push_back(act2(9, 1));
                m_words.push_back((op == 4'd3) ? act(act2(2, 5), 3) : act2(2, 5));
            end
            4'd4: begin m_words.push_back(act2(6, 11)); m_words.push_back(act2(9, 5)); end
            4'd5: m_words.push_back(act2(4, 0));
            4'd6: begin m_words.push_back(act2(6, 11)); m_words.push_back(act2(4, 8)); end
            4'd7: m_words.push_back(act2(6, 12));
            4'd8: m_words.push_back(fz ? act2(6, 12) : IDLE_W);
            4'd9: m_words.push_back(fc ? act2(6, 12) : IDLE_W);
            default: m_words.push_back(IDLE_W);
        endcase
        m_pos = 3;
    endtask

    task automatic model_step();
        if (!bus.step_en || m_halt) return;
        if (m_idle) begin
            m_idle = 1'b0;
            model_fetch();
        end else if (m_pos == 2) begin
            model_exec(bus.opcode, bus.flag_z, bus.flag_c);
        end else if (m_pos == m_words.size() - 1) begin
            model_fetch();
        end else begin
            m_pos++;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int          et;
        logic [14:0] ec;
        bit          ed;
        et = m_idle ? T_IDLE : m_pos;
        ec = m_idle ? IDLE_W : m_words[m_pos];
        ed = !m_idle && (m_pos >= 3) && (m_pos == m_words.size() - 1);
        chk({tag, "_tstate"}, 32'(bus.tstate), 32'(et));
        chk({tag, "_ctrl"}, 32'(bus.ctrl), 32'(ec));
        chk({tag, "_done"}, 32'(bus.instr_done), 32'(ed));
        chk({tag, "_halted"}, 32'(bus.halted), 32'(m_halt));
    endtask

    task automatic cyc(input bit se, input logic [3:0] op, input bit fz, input bit fc,
                       input string tag);
        @(negedge clk);
        bus.step_en = se;
        bus.opcode  = op;
        bus.flag_z  = fz;
        bus.flag_c  = fc;
        @(posedge clk);
        if (!rst) model_step();
        #1;
        check_all(tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        rst           = 1'b1;
        bus.step_en   = 1'b0;
        bus.opcode    = '0;
        bus.flag_z    = 1'b0;
        bus.flag_c    = 1'b0;
        bus_h.step_en = 1'b0;
        bus_h.opcode  = '0;
        bus_h.flag_z  = 1'b0;
        bus_h.flag_c  = 1'b0;
        model_reset();
        #12;
        check_all("reset");
        chk("reset_h_halted", 32'(bus_h.halted), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Fetch words and a full ADD, ending in the next fetch.
        cyc(1'b1, 4'd2, 1'b0, 1'b0, "fetch");
        chk("t0_word", 32'(bus.ctrl), 32'h27E3);
        repeat (8) cyc(1'b1, 4'd2, 1'b0, 1'b0, "add");

        // JZ taken then not taken.
        cyc(1'b1, 4'd8, 1'b1, 1'b0, "jz_taken");
        chk("jz_taken_word", 32'(bus.ctrl), 32'h1FA3);
        repeat (3) cyc(1'b1, 4'd8, 1'b0, 1'b0, "jz_fetch");
        cyc(1'b1, 4'd8, 1'b0, 1'b0, "jz_not_taken");
        chk("jz_not_word", 32'(bus.ctrl), 32'h0FE3);
        chk("jz_not_done", 32'(bus.instr_done), 32'd1);

        // Random traffic, HLT excluded so the run keeps moving.
        repeat (400) begin
            logic [3:0] op;
            op = 4'($urandom_range(1, 15));
            cyc(($urandom_range(0, 3) != 0), op, 1'($urandom), 1'($urandom), "rand");
        end

        // SUB paused in T4, then reset asserted while paused.
        for (int i = 0; i < 20 && !(!m_idle && m_pos == 4 && m_words.size() == 6); i++)
            cyc(1'b1, 4'd3, 1'b0, 1'b0, "sub_run");
        chk("reach_sub_t4", 32'(bus.tstate), 32'd4);
        repeat (5) cyc(1'b0, 4'($urandom), 1'($urandom), 1'($urandom), "sub_pause");
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        @(posedge clk);
        #1 check_all("rst_held");
        @(negedge clk);
        rst = 1'b0;

        // HLT freezes everything until reset.
        repeat (4) cyc(1'b1, 4'd0, 1'b0, 1'b0, "hlt");
        chk("hlt_halted", 32'(bus.halted), 32'd1);
        repeat (20) cyc(1'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), "hlt_hold");
        @(negedge clk);
        rst           = 1'b1;
        bus_h.step_en = 1'b1;
        bus_h.opcode  = 4'hB;
        #1;
        model_reset();
        check_all("hlt_rst");
        @(negedge clk);
        rst = 1'b0;

        // Undefined opcode: NOP on one instance, halt on the other.
        repeat (4) cyc(1'b1, 4'hB, 1'b0, 1'b0, "undef_nop");
        chk("undef_h_halted", 32'(bus_h.halted), 32'd1);
        chk("undef_h_tstate", 32'(bus_h.tstate), 32'd3);
        chk("undef_h_ctrl", 32'(bus_h.ctrl), 32'h0FE3);
        chk("undef_h_done", 32'(bus_h.instr_done), 32'd1);
        cyc(1'b1, 4'hB, 1'b0, 1'b0, "undef_next");
        chk("undef_nop_t0", 32'(bus.tstate), 32'd0);
        chk("undef_h_frozen", 32'(bus_h.tstate), 32'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
